// File: rtl/exu_seq_pkg.sv
// Shared opcode, state, exception and load/store width definitions for the
// execute-stage sequencer.
package exu_seq_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0010011;
    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_ILLEGAL  = 2'd1,
        EXC_MISALIGN = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } exc_t;

endpackage

// File: rtl/exu_seq_lsu_fmt.sv
// Combinational LSU formatting: store lane placement, load lane extraction
// with sign/zero extension, and alignment check.
module exu_seq_lsu_fmt
    import exu_seq_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [2:0]      func3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned
);

    logic [15:0]        ld_shift;
    logic signed [7:0]  ld_b;
    logic signed [15:0] ld_h;

    always_comb begin
        ld_shift   = 16'(ld_word >> {addr_lo, 3'b000});
        ld_b       = ld_shift[7:0];
        ld_h       = ld_shift;
        wmask      = 4'hF;
        wdata      = st_data;
        misaligned = 1'b0;
        ld_data    = ld_word;

        // func3[1:0] encodes the access size for both loads and stores
        case (func3[1:0])
            2'b00: begin
                wmask = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wmask      = 4'b0011 << addr_lo;
                wdata      = {2{st_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: misaligned = (addr_lo != 2'b00);
        endcase

        case (func3)
            F3_B:    ld_data = XLEN'(ld_b);
            F3_H:    ld_data = XLEN'(ld_h);
            F3_BU:   ld_data = XLEN'(ld_shift[7:0]);
            F3_HU:   ld_data = XLEN'(ld_shift);
            F3_W:    ld_data = ld_word;
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/exu_seq.sv
// Multicycle execute-stage sequencer: holds one decoded instruction for the
// external ALU, resolves next PC, runs one LSU transaction, hands off to WBU.
module exu_seq
    import exu_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_func3,
    input  logic [6:0]      in_func7,
    output logic [XLEN-1:0] exu_op1,
    output logic [XLEN-1:0] exu_op2,
    output logic [6:0]      exu_opcode,
    output logic [2:0]      exu_func3,
    output logic [6:0]      exu_func7,
    input  logic [XLEN-1:0] exu_res,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wen,
    output logic [3:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_rd_wen,
    output logic [XLEN-1:0] out_rd_data,
    output logic [XLEN-1:0] out_next_pc,
    output logic [1:0]      out_exc
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, rs2_q, imm_q, op1_q, op2_q, addr_q;
    logic [6:0]      opcode_q, func7_q;
    logic [2:0]      func3_q;
    logic [7:0]      cnt_q;
    logic            rd_wen_q;
    logic [XLEN-1:0] rd_data_q, next_pc_q;
    exc_t            exc_q;

    logic [XLEN-1:0] op1_sel, op2_sel, pc4, tgt;
    logic [XLEN-1:0] ex_rd_data, ex_next_pc;
    logic            ex_rd_wen;
    exc_t            ex_exc;
    logic            is_load, is_mem, timeout, req_active;
    logic [1:0]      lsu_addr_lo;
    logic [3:0]      lsu_wmask;
    logic [XLEN-1:0] lsu_wdata, lsu_ld_data;
    logic            lsu_misaligned;

    assign is_load    = (opcode_q == OPCODE_LOAD);
    assign is_mem     = is_load || (opcode_q == OPCODE_STORE);
    assign timeout    = (cnt_q == 8'(MEM_TIMEOUT));
    assign req_active = (state == S_MEM_REQ);
    // Alignment is judged on the live ALU result in EXEC, on the latched address afterwards
    assign lsu_addr_lo = (state == S_EXEC) ? exu_res[1:0] : addr_q[1:0];

    exu_seq_lsu_fmt #(.XLEN(XLEN)) u_fmt (
        .func3      (func3_q),
        .addr_lo    (lsu_addr_lo),
        .st_data    (rs2_q),
        .ld_word    (mem_rdata),
        .wmask      (lsu_wmask),
        .wdata      (lsu_wdata),
        .ld_data    (lsu_ld_data),
        .misaligned (lsu_misaligned)
    );

    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        case (in_opcode)
            OPCODE_R, OPCODE_BRANCH: begin
                op1_sel = in_rs1;
                op2_sel = in_rs2;
            end
            OPCODE_ARITH, OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: begin
                op1_sel = in_rs1;
                op2_sel = in_imm;
            end
            OPCODE_LUI: op2_sel = in_imm;
            OPCODE_AUIPC, OPCODE_JAL: begin
                op1_sel = in_pc;
                op2_sel = in_imm;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc4        = pc_q + XLEN'(4);
        tgt        = pc_q + imm_q;
        ex_rd_wen  = 1'b0;
        ex_rd_data = '0;
        ex_next_pc = pc4;
        ex_exc     = EXC_NONE;
        case (opcode_q)
            OPCODE_BRANCH: if (exu_res[0]) ex_next_pc = tgt;
            OPCODE_JAL: begin
                ex_rd_wen  = 1'b1;
                ex_rd_data = pc4;
                ex_next_pc = exu_res;
            end
            OPCODE_JALR: begin
                ex_rd_wen  = 1'b1;
                ex_rd_data = pc4;
                ex_next_pc = {exu_res[XLEN-1:1], 1'b0};
            end
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_ARITH, OPCODE_R: begin
                ex_rd_wen  = 1'b1;
                ex_rd_data = exu_res;
            end
            OPCODE_SYSTEM: ;
            OPCODE_LOAD, OPCODE_STORE: if (lsu_misaligned) ex_exc = EXC_MISALIGN;
            default: ex_exc = EXC_ILLEGAL;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (in_valid) state_nxt = S_EXEC;
            S_EXEC:     state_nxt = (is_mem && !lsu_misaligned) ? S_MEM_REQ : S_DONE;
            S_MEM_REQ:  if (mem_req_ready) state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_rsp_valid || timeout) state_nxt = S_DONE;
            S_DONE:     if (out_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            addr_q    <= '0;
            opcode_q  <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            cnt_q     <= '0;
            rd_wen_q  <= 1'b0;
            rd_data_q <= '0;
            next_pc_q <= '0;
            exc_q     <= EXC_NONE;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    pc_q     <= in_pc;
                    rs2_q    <= in_rs2;
                    imm_q    <= in_imm;
                    opcode_q <= in_opcode;
                    func3_q  <= in_func3;
                    func7_q  <= in_func7;
                    op1_q    <= op1_sel;
                    op2_q    <= op2_sel;
                end
                S_EXEC: begin
                    addr_q    <= exu_res;
                    rd_wen_q  <= ex_rd_wen;
                    rd_data_q <= ex_rd_data;
                    next_pc_q <= ex_next_pc;
                    exc_q     <= ex_exc;
                end
                S_MEM_REQ: if (mem_req_ready) cnt_q <= '0;
                S_MEM_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A response in the timeout cycle still completes normally
                    if (mem_rsp_valid) begin
                        rd_wen_q  <= is_load;
                        rd_data_q <= is_load ? lsu_ld_data : '0;
                    end else if (timeout) begin
                        rd_wen_q <= 1'b0;
                        exc_q    <= EXC_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state == S_IDLE);
    assign exu_op1       = op1_q;
    assign exu_op2       = op2_q;
    assign exu_opcode    = opcode_q;
    assign exu_func3     = func3_q;
    assign exu_func7     = func7_q;
    assign mem_req_valid = req_active;
    assign mem_addr      = req_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wen       = req_active && (opcode_q == OPCODE_STORE);
    assign mem_wmask     = req_active ? lsu_wmask : 4'h0;
    assign mem_wdata     = req_active ? lsu_wdata : '0;
    assign out_valid     = (state == S_DONE);
    assign out_rd_wen    = rd_wen_q;
    assign out_rd_data   = rd_data_q;
    assign out_next_pc   = next_pc_q;
    assign out_exc       = exc_q;

endmodule

// File: doc/exu_seq.md
Name: exu_seq

Overview:
- Multicycle execute-stage sequencer in the npc core, between IDU and WBU.
- Latches one decoded instruction, holds operands and opcode/func fields stable for the external EXU (ALU) instance, and samples its result.
- Computes next PC, sequences one LSU memory transaction for loads and stores, then presents a write-back packet to WBU.
- Uses valid/ready handshakes on every side and processes one instruction at a time.

Parameters:
- XLEN, 32, datapath width.
- MEM_TIMEOUT, 255, maximum number of cycles in MEM_WAIT before the bus-error flag is raised (8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  IDU packet valid.
- in_ready  out  1  sequencer can accept a packet.
- in_pc, in_rs1, in_rs2, in_imm  in  XLEN each  instruction PC, register values, sign-extended immediate.
- in_opcode  in  7, in_func3  in  3, in_func7  in  7  decoded instruction fields.
- exu_op1, exu_op2  out  XLEN  operands driven to the EXU.
- exu_opcode  out  7, exu_func3  out  3, exu_func7  out  7  fields driven to the EXU.
- exu_res  in  XLEN  combinational EXU result.
- mem_req_valid  out  1; mem_req_ready  in  1.
- mem_addr  out  XLEN; mem_wdata  out  XLEN; mem_wen  out  1; mem_wmask  out  4.
- mem_rsp_valid  in  1; mem_rdata  in  XLEN.
- out_valid  out  1; out_ready  in  1  WBU handshake.
- out_rd_wen  out  1; out_rd_data  out  XLEN; out_next_pc  out  XLEN.
- out_exc  out  2  exception code: 0 none, 1 illegal opcode, 2 misaligned access, 3 bus timeout.

Behaviour:
- States: IDLE, EXEC, MEM_REQ, MEM_WAIT, DONE. Reset forces IDLE.
- Reset values: all outputs 0 except in_ready=1. All packet registers clear to 0.
- IDLE: in_ready=1. When in_valid=1, latch all in_* fields and go to EXEC. No other state accepts input.
- Operand selection, registered and stable from EXEC until the next IDLE accept:
  - R, BRANCH: (rs1, rs2).
  - ARITH, LOAD, STORE, JALR: (rs1, imm).
  - LUI: (0, imm).
  - AUIPC, JAL: (pc, imm).
  - All others: (0, 0).
  - exu_opcode/func3/func7 mirror the latched fields.
- EXEC, one cycle: sample exu_res. Let pc4 = pc+4 and tgt = pc+imm (local adders, mod 2^XLEN).
  - BRANCH: taken = exu_res[0]; next_pc = taken ? tgt : pc4; rd_wen=0.
  - JAL: rd_data=pc4, rd_wen=1, next_pc=exu_res.
  - JALR: rd_data=pc4, rd_wen=1, next_pc=exu_res with bit0 cleared.
  - LUI, AUIPC, ARITH, R: rd_data=exu_res, rd_wen=1, next_pc=pc4.
  - SYSTEM (1110011): rd_wen=0, next_pc=pc4, no exception.
  - LOAD, STORE: addr = exu_res.
    - Misaligned (half access with addr[0]=1, word access with addr[1:0]!=0): exc=2, rd_wen=0, go to DONE.
    - Otherwise go to MEM_REQ.
  - Any other opcode: exc=1, rd_wen=0, next_pc=pc4.
  - Non-memory instructions go to DONE.
- MEM_REQ:
  - mem_req_valid=1 with mem_addr = {addr[XLEN-1:2], 2'b00}.
  - mem_wen=1 for STORE only.
  - mem_wmask: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hF.
  - mem_wdata = rs2 replicated to its byte lanes.
  - Hold all request signals stable until mem_req_ready=1, then go to MEM_WAIT and clear the timeout counter.
- MEM_WAIT:
  - Counter increments each cycle.
  - mem_rsp_valid=1 goes to DONE. For LOAD, extract the lane by addr[1:0]; sign-extend for func3 000/001, zero-extend for 100/101; word for 010. Set rd_wen=1. STORE sets rd_wen=0.
  - Counter reaching MEM_TIMEOUT with no response: exc=3, rd_wen=0, go to DONE.
  - A response arriving in the same cycle as the timeout wins (no exception).
- DONE: out_valid=1; packet held stable. When out_ready=1, go to IDLE, with out_valid falling the next cycle. There is no same-cycle bypass from DONE to accept.
- Any exception: rd_wen forced 0, next_pc=pc4.
- Reset mid-transaction: request is abandoned immediately; mem_req_valid=0 asynchronously. A late mem_rsp_valid while in IDLE is ignored.
- Throughput: minimum 3 cycles per non-memory instruction (accept, EXEC, DONE handshake).

Decomposition:
- Shared package holds:
  - the OPCODE_* constants for LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ARITH, R, SYSTEM;
  - the state enum;
  - the exception-code enum;
  - load/store func3 width constants.
- One sub-module, exu_seq_lsu_fmt: combinational wmask/wdata lane placement, load extraction/extension, and misalignment detect.

Test Plan:
- ADDI: rs1=5, imm=-3, exu_res=2 -> exu_op1=5, exu_op2=0xFFFFFFFD; out after 3 cycles with rd_wen=1, rd_data=2, next_pc=pc+4.
- BNE: pc=0x80000010, imm=0x20, exu_res bit0=1 -> next_pc=0x80000030, rd_wen=0. Same with exu_res bit0=0 -> 0x80000014.
- LB: addr=0x80001003, mem_rdata=0x80FFFFFF -> mem_addr=0x80001000, rd_data=0xFFFFFF80. LBU -> 0x00000080.
- SH: addr=0x2 with rs2=0x1234ABCD -> mem_wmask=4'b1100, wdata[31:16]=0xABCD, mem_wen=1, rd_wen=0. SH at addr=0x3 -> no mem_req_valid, out_exc=2.
- mem_req_ready held low 5 cycles, then no response for 255 cycles -> request stable throughout, out_exc=3. In a second case, rst asserted in MEM_WAIT -> IDLE, in_ready=1, no out_valid.
- opcode 0x7F -> out_exc=1. out_ready held low 4 cycles in DONE -> packet stable, in_ready=0 throughout.
